// File: rtl/div_ctrl_if.sv
// Execute-stage <-> iterative divider handshake bundle.
// The divider connects through the slave modport, the execute stage through master.
interface div_ctrl_if #(
  parameter int unsigned DIV_W = 32
);
  logic               div_start_i;
  logic               div_signed_i;
  logic [DIV_W-1:0]   div_opdata1_i;
  logic [DIV_W-1:0]   div_opdata2_i;
  logic               flush_i;
  logic               div_ack_i;
  logic [2*DIV_W-1:0] divres_o;
  logic               div_ready_o;
  logic               div_busy_o;
  logic               div_by_zero_o;
  logic               stallreq_div_o;

  modport master (
    output div_start_i, div_signed_i, div_opdata1_i, div_opdata2_i, flush_i, div_ack_i,
    input  divres_o, div_ready_o, div_busy_o, div_by_zero_o, stallreq_div_o
  );

  modport slave (
    input  div_start_i, div_signed_i, div_opdata1_i, div_opdata2_i, flush_i, div_ack_i,
    output divres_o, div_ready_o, div_busy_o, div_by_zero_o, stallreq_div_o
  );
endinterface

// File: rtl/div_ctrl.sv
// Radix-4 iterative DIV/DIVU sequencer with sign fixup, result hold and stall request.
// Define DIV_EARLY_OUT_EN to finish |dividend| < |divisor| requests straight from IDLE.
module div_ctrl #(
  parameter int unsigned DIV_W = 32
) (
  input  logic       cpu_clk_50M,
  input  logic       cpu_rst_n,
  div_ctrl_if.slave  div_bus
);

  localparam int unsigned STEPS = DIV_W / 2;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] BY_ZERO = 3'd1;
  localparam logic [2:0] ON      = 3'd2;
  localparam logic [2:0] FIX     = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [2*DIV_W+1:0] partial;
  logic [DIV_W-1:0]   divisor_q;
  logic               sign1_q;
  logic               sign2_q;
  logic               signed_q;
  logic [2*DIV_W-1:0] divres_q;
  logic               ready_q;
  logic               dbz_q;

  logic [DIV_W-1:0]   op1_mag;
  logic [DIV_W-1:0]   op2_mag;
  logic [DIV_W+2:0]   trial;
  logic [DIV_W+2:0]   d1;
  logic [DIV_W+2:0]   d2;
  logic [DIV_W+2:0]   d3;
  logic [DIV_W+2:0]   sub1;
  logic [DIV_W+2:0]   sub2;
  logic [DIV_W+2:0]   sub3;
  logic [DIV_W+1:0]   rem_next;
  logic [1:0]         digit;
  logic [2*DIV_W+1:0] next_partial;
  logic [DIV_W-1:0]   quo;
  logic [DIV_W-1:0]   rem;
  logic [DIV_W-1:0]   quo_fix;
  logic [DIV_W-1:0]   rem_fix;
  logic               unused_top;

  assign op1_mag = (div_bus.div_signed_i && div_bus.div_opdata1_i[DIV_W-1]) ?
                   -div_bus.div_opdata1_i : div_bus.div_opdata1_i;
  assign op2_mag = (div_bus.div_signed_i && div_bus.div_opdata2_i[DIV_W-1]) ?
                   -div_bus.div_opdata2_i : div_bus.div_opdata2_i;

  // Window is the running remainder shifted left by two with the next dividend pair
  // appended; the remainder is always < divisor so the top partial bits stay zero.
  assign trial = {1'b0, partial[2*DIV_W-1:DIV_W-2]};
  assign d1    = {3'b000, divisor_q};
  assign d2    = {2'b00, divisor_q, 1'b0};
  assign d3    = d1 + d2;
  assign sub1  = trial - d1;
  assign sub2  = trial - d2;
  assign sub3  = trial - d3;

  always_comb begin
    rem_next = trial[DIV_W+1:0];
    digit    = 2'd0;
    if (!sub3[DIV_W+2]) begin
      rem_next = sub3[DIV_W+1:0];
      digit    = 2'd3;
    end else if (!sub2[DIV_W+2]) begin
      rem_next = sub2[DIV_W+1:0];
      digit    = 2'd2;
    end else if (!sub1[DIV_W+2]) begin
      rem_next = sub1[DIV_W+1:0];
      digit    = 2'd1;
    end
  end

  assign next_partial = {rem_next, partial[DIV_W-3:0], digit};
  assign quo          = partial[DIV_W-1:0];
  assign rem          = partial[2*DIV_W-1:DIV_W];
  assign quo_fix      = (signed_q && (sign1_q ^ sign2_q)) ? -quo : quo;
  assign rem_fix      = (signed_q && sign1_q) ? -rem : rem;
  assign unused_top   = ^partial[2*DIV_W+1:2*DIV_W];

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      partial   <= '0;
      divisor_q <= '0;
      sign1_q   <= 1'b0;
      sign2_q   <= 1'b0;
      signed_q  <= 1'b0;
      divres_q  <= '0;
      ready_q   <= 1'b0;
      dbz_q     <= 1'b0;
    end else if (div_bus.flush_i) begin
      state    <= IDLE;
      cnt      <= '0;
      divres_q <= '0;
      ready_q  <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (div_bus.div_start_i) begin
            if (div_bus.div_opdata2_i == '0) begin
              state <= BY_ZERO;
            end
`ifdef DIV_EARLY_OUT_EN
            else if (op1_mag < op2_mag) begin
              state    <= DONE;
              divres_q <= {div_bus.div_opdata1_i, {DIV_W{1'b0}}};
              ready_q  <= 1'b1;
            end
`endif
            else begin
              state     <= ON;
              cnt       <= '0;
              partial   <= {{(DIV_W+2){1'b0}}, op1_mag};
              divisor_q <= op2_mag;
              sign1_q   <= div_bus.div_opdata1_i[DIV_W-1];
              sign2_q   <= div_bus.div_opdata2_i[DIV_W-1];
              signed_q  <= div_bus.div_signed_i;
            end
          end
        end
        BY_ZERO: begin
          state    <= DONE;
          divres_q <= '0;
          ready_q  <= 1'b1;
          dbz_q    <= 1'b1;
        end
        ON: begin
          partial <= next_partial;
          cnt     <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(STEPS - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          state    <= DONE;
          divres_q <= {rem_fix, quo_fix};
          ready_q  <= 1'b1;
        end
        DONE: begin
          if (div_bus.div_ack_i || !div_bus.div_start_i) begin
            state    <= IDLE;
            divres_q <= '0;
            ready_q  <= 1'b0;
            dbz_q    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign div_bus.divres_o       = divres_q;
  assign div_bus.div_ready_o    = ready_q;
  assign div_bus.div_busy_o     = (state != IDLE);
  assign div_bus.div_by_zero_o  = dbz_q;
  assign div_bus.stallreq_div_o = div_bus.div_start_i & ~ready_q & ~div_bus.flush_i;

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
- Sequencing controller for the execute-stage iterative radix-4 divider.
- Accepts DIV/DIVU requests from the execute stage and captures the operands.
- Runs the 2-bit-per-cycle shift/subtract iterations, applies the sign fixup, and holds the 64-bit {remainder, quotient} result until the pipeline consumes it.
- Generates the execute-stage stall request and cancels the operation on a pipeline flush.

Parameters:
- DIV_W, 32, operand width. Must be even. Iteration count is DIV_W/2.

Ports:
- cpu_clk_50M  in  1  system clock; all state changes on the rising edge.
- cpu_rst_n  in  1  asynchronous active-low reset.
- div_start_i  in  1  level request; high while DIV/DIVU occupies the execute stage.
- div_signed_i  in  1  1 = DIV (signed), 0 = DIVU.
- div_opdata1_i  in  DIV_W  dividend.
- div_opdata2_i  in  DIV_W  divisor.
- flush_i  in  1  exception flush; cancels any operation.
- div_ack_i  in  1  pipeline advanced past the divide; result consumed.
- divres_o  out  2*DIV_W  {remainder, quotient}.
- div_ready_o  out  1  divres_o valid.
- div_busy_o  out  1  state is not IDLE.
- div_by_zero_o  out  1  current result came from a zero divisor.
- stallreq_div_o  out  1  = div_start_i & ~div_ready_o & ~flush_i (combinational).

Behaviour:
- Reset: asynchronous and active-low. State goes to IDLE. divres_o=0, div_ready_o=0, div_busy_o=0, div_by_zero_o=0, iteration counter=0. Reset mid-operation abandons the operation immediately.
- States: IDLE, BY_ZERO, ON, FIX, DONE.
- IDLE:
  - div_start_i=1 and divisor=0: go to BY_ZERO.
  - div_start_i=1 and divisor≠0: go to ON.
  - On entry to ON, capture the operand magnitudes (two's-complement negate when signed and MSB=1), the original sign bits and div_signed_i. Clear the counter and the 2*DIV_W+2-bit partial register.
  - Operand changes after capture are ignored.
- ON: one radix-4 step per cycle.
  - Compute partial − d, partial − 2d, partial − 3d, each DIV_W+3 bits wide.
  - Select the largest non-negative result; the shifted-in quotient digit is 3, 2 or 1.
  - If all three are negative, shift the partial left by 2 with quotient digit 0.
  - After DIV_W/2 steps, go to FIX.
- FIX:
  - Negate the quotient if signed and (sign1 ^ sign2).
  - Negate the remainder if signed and sign1=1.
  - −2^(DIV_W−1) / −1 wraps: quotient 0x80000000, remainder 0.
  - Go to DONE.
- BY_ZERO: next cycle go to DONE with result 0 and div_by_zero_o=1.
- DONE:
  - div_ready_o=1; divres_o is stable.
  - On div_ack_i=1 or div_start_i=0, go to IDLE next edge and clear divres_o, div_ready_o and div_by_zero_o.
  - Otherwise hold indefinitely; external stalls are tolerated.
- Latency, counted in rising edges from the edge that samples div_start_i in IDLE to div_ready_o=1:
  - nonzero divisor: DIV_W/2+2 (18 for DIV_W=32).
  - zero divisor: 2.
- After a DONE exit there is at least one IDLE cycle before a new capture.
- flush_i=1 in any state: next state IDLE, all outputs cleared. Flush wins over a simultaneous start or ack.
- div_ack_i outside DONE is ignored.

Optional Feature:
- Macro: DIV_EARLY_OUT_EN.
- Defined: in IDLE with a nonzero divisor and |dividend| < |divisor| (magnitudes compared unsigned), go directly to DONE.
  - Result: quotient 0, remainder = original div_opdata1_i.
  - div_ready_o rises 1 edge after sampling.
- Undefined: no magnitude comparator is built; every nonzero divide takes DIV_W/2+2 edges.

Test Plan:
- DIVU 100/7, ack on first ready cycle -> stallreq high for 18 cycles; divres_o={32'd2, 32'd14}; cleared 1 cycle after ack.
- DIV 0xFFFFFFF9 (−7) / 2 -> divres_o={0xFFFFFFFF, 0xFFFFFFFD}. DIV 7/0xFFFFFFFE -> {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000/0xFFFFFFFF -> {0x00000000, 0x80000000}. DIVU 0xFFFFFFFF/1 -> {0, 0xFFFFFFFF}.
- Divisor 0 -> div_ready_o after 2 edges, divres_o=0, div_by_zero_o=1, stallreq_div_o low once ready.
- Flush at ON step 8 -> next edge IDLE, busy=0, ready=0. A fresh DIVU 9/3 then completes in 18 edges with {0, 3}. Async reset pulse mid-ON -> outputs 0 without a clock edge.
- Hold ack low for 5 cycles in DONE -> divres_o stable throughout. With DIV_EARLY_OUT_EN, DIVU 5/9 -> ready after 1 edge, {5, 0}.
